// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD serial loader.
//   BCD_MAX  - largest legal BCD digit value
//   DIGIT_W  - width of one BCD digit
//   bcd_state_e - loader FSM states: SHIFT (collecting bits), HOLD (digit held for downstream)
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } bcd_state_e;

endpackage

// File: rtl/bcd_range_chk.sv
// Combinational BCD range check.
//   value  - 4-bit candidate digit
//   is_bcd - high when value <= 9
module bcd_range_chk
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic               is_bcd
);

  assign is_bcd = (value <= BCD_MAX);

endmodule

// File: rtl/bcd_serial_loader.sv
// Serial-to-parallel BCD digit loader with valid/ready handshakes on both sides.
// Four accepted serial bits form one frame; legal frames (0..9) are presented on digit with
// dout_vld, illegal frames (10..15) are dropped and flagged by a one-cycle err pulse.
//   clk, rst_n     - clock, synchronous active-low reset
//   sin, sin_vld   - serial bit and its valid; sin_rdy - loader can accept a bit
//   clr            - discard the partial frame (does not touch a held digit)
//   digit          - assembled digit, digit[3..0] drive downstream inputs A..D
//   dout_vld/rdy   - output handshake
//   err            - one-cycle pulse on a non-BCD frame
//   err_cnt        - saturating err count, present only when BCD_ERR_CNT_EN is defined
// Parameter MSB_FIRST: 1 = first serial bit lands in digit[3], 0 = first bit lands in digit[0].
module bcd_serial_loader
  import bcd_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sin,
  input  logic               sin_vld,
  output logic               sin_rdy,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               dout_vld,
  input  logic               dout_rdy,
`ifdef BCD_ERR_CNT_EN
  output logic [7:0]         err_cnt,
`endif
  output logic               err
);

  bcd_state_e         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DIGIT_W-1:0] sr_q, sr_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               err_q, err_d;

  logic               accept;
  logic               frame_done;
  logic [DIGIT_W-1:0] frame;
  logic               is_bcd;

  assign dout_vld = (state_q == HOLD);
  // Only the frame-completing bit can stall: it needs the output register free.
  assign sin_rdy  = !((cnt_q == 2'd3) && dout_vld && !dout_rdy);
  assign accept   = sin_vld && sin_rdy;
  assign frame_done = accept && !clr && (cnt_q == 2'd3);

  // Frame as it would look with the current bit shifted in.
  assign frame = (MSB_FIRST != 0) ? {sr_q[DIGIT_W-2:0], sin} : {sin, sr_q[DIGIT_W-1:1]};

  bcd_range_chk u_range_chk (
    .value  (frame),
    .is_bcd (is_bcd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    digit_d = digit_q;
    err_d   = frame_done && !is_bcd;

    if (clr) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = frame_done ? '0 : frame;
    end

    unique case (state_q)
      SHIFT: begin
        if (frame_done && is_bcd) begin
          state_d = HOLD;
          digit_d = frame;
        end
      end
      HOLD: begin
        // A completion here implies dout_rdy, so the held digit is consumed this cycle.
        if (frame_done && is_bcd) begin
          digit_d = frame;
        end else if (dout_rdy) begin
          state_d = SHIFT;
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHIFT;
      cnt_q   <= '0;
      sr_q    <= '0;
      digit_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      digit_q <= digit_d;
      err_q   <= err_d;
    end
  end

  assign digit = digit_q;
  assign err   = err_q;

`ifdef BCD_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bcd_serial_loader.sv
// Directed self-checking bench for bcd_serial_loader (MSB_FIRST = 1).
module tb_bcd_serial_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin;
  logic       sin_vld;
  logic       sin_rdy;
  logic       clr;
  logic [3:0] digit;
  logic       dout_vld;
  logic       dout_rdy;
  logic       err;
`ifdef BCD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_loader #(
    .MSB_FIRST (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .sin_vld  (sin_vld),
    .sin_rdy  (sin_rdy),
    .clr      (clr),
    .digit    (digit),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
`ifdef BCD_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .err      (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one clock edge; returns #1 after that edge.
  task automatic send_bit(input logic b);
    sin     = b;
    sin_vld = 1'b1;
    @(posedge clk);
    #1;
    sin_vld = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) send_bit(n[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    sin      = 1'b0;
    sin_vld  = 1'b0;
    clr      = 1'b0;
    dout_rdy = 1'b1;
    idle(2);
    rst_n = 1'b1;
    check("rst_dout_vld", {7'd0, dout_vld}, 8'd0);
    check("rst_digit", {4'd0, digit}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    check("rst_sin_rdy", {7'd0, sin_rdy}, 8'd1);

    // Frame 0010 -> digit 2, visible right after the 4th bit's edge.
    send_nib(4'b0010);
    check("f2_vld", {7'd0, dout_vld}, 8'd1);
    check("f2_digit", {4'd0, digit}, 8'h02);
    check("f2_err", {7'd0, err}, 8'd0);
    idle(1);
    check("f2_consumed", {7'd0, dout_vld}, 8'd0);

    // Frame 1111 -> err pulse, no digit.
    send_nib(4'b1111);
    check("fF_err", {7'd0, err}, 8'd1);
    check("fF_vld", {7'd0, dout_vld}, 8'd0);
    idle(1);
    check("fF_err_one_cycle", {7'd0, err}, 8'd0);
    // Counter back to 0: next 4 bits form a fresh frame.
    send_nib(4'b0011);
    check("after_err_digit", {4'd0, digit}, 8'h03);
    check("after_err_vld", {7'd0, dout_vld}, 8'd1);
    idle(1);

    // Back-pressure: 8 held, 9 stalls on its last bit, then follows with no bubble.
    dout_rdy = 1'b0;
    send_nib(4'b1000);
    check("bp_digit8", {4'd0, digit}, 8'h08);
    check("bp_vld8", {7'd0, dout_vld}, 8'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("bp_sin_rdy_low", {7'd0, sin_rdy}, 8'd0);
    sin     = 1'b1;
    sin_vld = 1'b1;
    idle(2);
    check("bp_hold_digit", {4'd0, digit}, 8'h08);
    check("bp_hold_vld", {7'd0, dout_vld}, 8'd1);
    dout_rdy = 1'b1;
    #1;
    check("bp_sin_rdy_high", {7'd0, sin_rdy}, 8'd1);
    idle(1);
    sin_vld = 1'b0;
    check("bp_digit9", {4'd0, digit}, 8'h09);
    check("bp_vld9", {7'd0, dout_vld}, 8'd1);
    check("bp_err9", {7'd0, err}, 8'd0);
    idle(1);
    check("bp_drained", {7'd0, dout_vld}, 8'd0);

    // Two partial bits, clr (with a competing valid bit), then 0001.
    send_bit(1'b1);
    send_bit(1'b1);
    clr     = 1'b1;
    sin     = 1'b1;
    sin_vld = 1'b1;
    idle(1);
    clr     = 1'b0;
    sin_vld = 1'b0;
    send_nib(4'b0001);
    check("clr_digit", {4'd0, digit}, 8'h01);
    check("clr_vld", {7'd0, dout_vld}, 8'd1);
    check("clr_err", {7'd0, err}, 8'd0);
    idle(1);

    // clr leaves a held digit alone.
    dout_rdy = 1'b0;
    send_nib(4'b0101);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_hold_digit", {4'd0, digit}, 8'h05);
    check("clr_hold_vld", {7'd0, dout_vld}, 8'd1);
    dout_rdy = 1'b1;
    idle(1);

    // Reset mid-frame after three bits, then 1001.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_vld", {7'd0, dout_vld}, 8'd0);
    check("midrst_err", {7'd0, err}, 8'd0);
    check("midrst_digit", {4'd0, digit}, 8'd0);
    send_bit(1'b1);
    check("midrst_no_early", {7'd0, dout_vld}, 8'd0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("midrst_digit9", {4'd0, digit}, 8'h09);
    check("midrst_vld9", {7'd0, dout_vld}, 8'd1);
    check("midrst_err9", {7'd0, err}, 8'd0);
    idle(1);
    check("midrst_single", {7'd0, dout_vld}, 8'd0);

`ifdef BCD_ERR_CNT_EN
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("cnt_rst", err_cnt, 8'd0);
    send_nib(4'b1111);
    check("cnt_one", err_cnt, 8'd1);
    for (int f = 1; f < 300; f++) send_nib(4'b1111);
    idle(1);
    check("cnt_sat", err_cnt, 8'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
